led_pattern_gen: RTL and testbench

Parametrised LED driver that generalises the fixed 8-LED binary blinker to N channels with four selectable display modes.
- Modes: binary count, Gray count, bouncing scanner, PWM breathing.
- Built-in tick prescaler and selectable output polarity.
- Sits directly between the board clock/reset generator and the LED pins; mode and enable come from straps, buttons or a control register.

---
 rtl/led_pattern_gen.sv | 193 +++++++++++++++++++
 tb/tb_led_pattern_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
//
// N-channel LED pattern driver with a built-in step prescaler. Four display
// modes are available: binary count, Gray count, bouncing scanner and PWM
// "breathing". The requested mode is only taken over on a pattern step, and
// the newly selected pattern then restarts from its initial state.
//
// Ports:
//   clk_i   - system clock, single clock domain
//   rst_ni  - asynchronous active-low reset, released synchronously upstream
//   en_i    - run enable; low freezes prescaler, PWM counter, pattern and LEDs
//   mode_i  - requested mode: 0 binary, 1 Gray, 2 scanner, 3 breathing
//   led_o   - registered LED pins; polarity set by ACTIVE_LOW
//   tick_o  - one-cycle strobe marking each pattern step
//   mode_o  - currently active (latched) mode
// -----------------------------------------------------------------------------
module led_pattern_gen #(
    parameter int TICK_DIV   = 2_500_000,
    parameter int N_LEDS     = 8,
    parameter int PWM_BITS   = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [1:0]        mode_i,
    output logic [N_LEDS-1:0] led_o,
    output logic              tick_o,
    output logic [1:0]        mode_o
);

    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam int POS_W   = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

    localparam logic [PRESC_W-1:0]  PRESC_LAST  = PRESC_W'(TICK_DIV - 1);
    localparam logic [POS_W-1:0]    POS_LAST    = POS_W'(N_LEDS - 1);
    localparam logic [PWM_BITS-1:0] LEVEL_MAX   = '1;
    // Pin pattern for "everything dark"; XOR-ing the lit mask with it applies
    // the board polarity.
    localparam logic [N_LEDS-1:0]   OFF_PATTERN = {N_LEDS{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        MODE_BIN     = 2'd0,
        MODE_GRAY    = 2'd1,
        MODE_SCAN    = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    // State
    logic [PRESC_W-1:0]  presc_q,    presc_d;
    logic [N_LEDS-1:0]   value_q,    value_d;     // shared by binary and Gray
    logic [POS_W-1:0]    pos_q,      pos_d;
    logic                scan_dn_q,  scan_dn_d;   // 0 = moving up
    logic [PWM_BITS-1:0] level_q,    level_d;
    logic                level_dn_q, level_dn_d;  // 0 = getting brighter
    logic [PWM_BITS-1:0] pwm_cnt_q,  pwm_cnt_d;
    mode_e               mode_q,     mode_d;
    logic [N_LEDS-1:0]   led_q,      led_d;

    logic                tick;
    logic [N_LEDS-1:0]   scan_lit;
    logic [N_LEDS-1:0]   lit;

    // A step only happens while running; freezing en_i also suppresses it.
    assign tick = en_i && (presc_q == PRESC_LAST);

    // One-hot decode of the scanner position.
    for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_scan
        assign scan_lit[gi] = (pos_q == POS_W'(gi));
    end

    // Lit mask for the currently active mode (1 = LED on).
    always_comb begin
        lit = '0;
        unique case (mode_q)
            MODE_BIN:     lit = value_q;
            MODE_GRAY:    lit = value_q ^ (value_q >> 1);
            MODE_SCAN:    lit = scan_lit;
            MODE_BREATHE: lit = {N_LEDS{pwm_cnt_q < level_q}};
            default:      lit = '0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        presc_d    = presc_q;
        value_d    = value_q;
        pos_d      = pos_q;
        scan_dn_d  = scan_dn_q;
        level_d    = level_q;
        level_dn_d = level_dn_q;
        pwm_cnt_d  = pwm_cnt_q;
        mode_d     = mode_q;
        led_d      = led_q;

        if (en_i) begin
            presc_d   = tick ? '0 : presc_q + PRESC_W'(1);
            pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
            led_d     = lit ^ OFF_PATTERN;

            if (tick) begin
                if (mode_e'(mode_i) != mode_q) begin
                    // Mode switch: restart the pattern instead of advancing.
                    mode_d     = mode_e'(mode_i);
                    value_d    = '0;
                    pos_d      = '0;
                    scan_dn_d  = 1'b0;
                    level_d    = '0;
                    level_dn_d = 1'b0;
                end else begin
                    unique case (mode_q)
                        MODE_BIN, MODE_GRAY: begin
                            value_d = value_q + N_LEDS'(1);
                        end
                        MODE_SCAN: begin
                            // Reversal jumps straight to the neighbour so each
                            // end LED is shown for a single step per sweep.
                            if (N_LEDS == 1) begin
                                pos_d = '0;
                            end else if (!scan_dn_q) begin
                                if (pos_q == POS_LAST) begin
                                    scan_dn_d = 1'b1;
                                    pos_d     = POS_LAST - POS_W'(1);
                                end else begin
                                    pos_d = pos_q + POS_W'(1);
                                end
                            end else begin
                                if (pos_q == '0) begin
                                    scan_dn_d = 1'b0;
                                    pos_d     = POS_W'(1);
                                end else begin
                                    pos_d = pos_q - POS_W'(1);
                                end
                            end
                        end
                        MODE_BREATHE: begin
                            // Same single-step reversal as the scanner, on the
                            // brightness level instead of the position.
                            if (!level_dn_q) begin
                                if (level_q == LEVEL_MAX) begin
                                    level_dn_d = 1'b1;
                                    level_d    = LEVEL_MAX - PWM_BITS'(1);
                                end else begin
                                    level_d = level_q + PWM_BITS'(1);
                                end
                            end else begin
                                if (level_q == '0) begin
                                    level_dn_d = 1'b0;
                                    level_d    = PWM_BITS'(1);
                                end else begin
                                    level_d = level_q - PWM_BITS'(1);
                                end
                            end
                        end
                        default: begin
                            value_d = value_q;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q    <= '0;
            value_q    <= '0;
            pos_q      <= '0;
            scan_dn_q  <= 1'b0;
            level_q    <= '0;
            level_dn_q <= 1'b0;
            pwm_cnt_q  <= '0;
            mode_q     <= MODE_BIN;
            led_q      <= OFF_PATTERN;
        end else begin
            presc_q    <= presc_d;
            value_q    <= value_d;
            pos_q      <= pos_d;
            scan_dn_q  <= scan_dn_d;
            level_q    <= level_d;
            level_dn_q <= level_dn_d;
            pwm_cnt_q  <= pwm_cnt_d;
            mode_q     <= mode_d;
            led_q      <= led_d;
        end
    end

    assign led_o  = led_q;
    assign tick_o = tick;
    assign mode_o = mode_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_gen
//
// Instance A (TICK_DIV=4, N_LEDS=4, PWM_BITS=3, active-low) is checked by a
// scoreboard: the stimulus pushes the expected {led_o, mode_o} for every step,
// and a monitor pops one entry on every tick_o and compares the pins sampled
// in that tick cycle (they show the pattern state about to be advanced).
// Instance B (TICK_DIV=8, N_LEDS=1, PWM_BITS=3, active-high) covers the
// single-LED scanner, inverted polarity and breathing duty per level.
// -----------------------------------------------------------------------------
module tb_led_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A
    logic       rst_a, en_a, tick_a;
    logic [1:0] mode_ia, mode_oa;
    logic [3:0] led_a;

    // Instance B
    logic       rst_b, en_b, tick_b;
    logic [1:0] mode_ib, mode_ob;
    logic [0:0] led_b;

    led_pattern_gen #(.TICK_DIV(4), .N_LEDS(4), .PWM_BITS(3), .ACTIVE_LOW(1)) dut_a (
        .clk_i (clk),
        .rst_ni(rst_a),
        .en_i  (en_a),
        .mode_i(mode_ia),
        .led_o (led_a),
        .tick_o(tick_a),
        .mode_o(mode_oa)
    );

    led_pattern_gen #(.TICK_DIV(8), .N_LEDS(1), .PWM_BITS(3), .ACTIVE_LOW(0)) dut_b (
        .clk_i (clk),
        .rst_ni(rst_b),
        .en_i  (en_b),
        .mode_i(mode_ib),
        .led_o (led_b),
        .tick_o(tick_b),
        .mode_o(mode_ob)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] led;
        logic [1:0] mode;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   tick_no = 0;

    // Hand-computed pin values (active low) sampled at successive ticks.
    logic [3:0] bin_exp  [17] = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8,
                                  4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'hF};
    logic [3:0] gray_exp [11] = '{4'hF, 4'hF, 4'hE, 4'hC, 4'hD, 4'h9, 4'h8, 4'hA,
                                  4'hB, 4'h3, 4'h2};
    logic [1:0] gray_mode[11] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
                                  2'd1, 2'd1, 2'd1};
    logic [3:0] scan_exp [12] = '{4'hF, 4'hE, 4'hD, 4'hB, 4'h7, 4'hB, 4'hD, 4'hE,
                                  4'hD, 4'hB, 4'h7, 4'hB};
    logic [1:0] scan_mode[12] = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                  2'd2, 2'd2, 2'd2, 2'd2};
    logic [3:0] chg_exp  [7]  = '{4'hD, 4'hF, 4'hE, 4'hD, 4'hC, 4'hE, 4'hD};
    logic [1:0] chg_mode [7]  = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2};
    // Lit cycles per 8-clock window of instance B in breathing mode.
    int         duty_exp [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("check %s: %0h ok", name, act);
        end
    endtask

    task automatic push_exp(input logic [3:0] led, input logic [1:0] mode);
        exp_t e;
        e.led  = led;
        e.mode = mode;
        sb_q.push_back(e);
    endtask

    // Wait for n ticks of instance A (sel_b=0) or B (sel_b=1), bounded.
    task automatic wait_ticks(input bit sel_b, input int n);
        for (int k = 0; k < n; k++) begin
            int cyc;
            cyc = 0;
            @(negedge clk);
            while (((sel_b ? tick_b : tick_a) !== 1'b1) && cyc < 64) begin
                @(negedge clk);
                cyc++;
            end
            if ((sel_b ? tick_b : tick_a) !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL tick_timeout: no tick within 64 cycles (got none, expected one)");
                return;
            end
        end
    endtask

    // Number of negedges until the next tick of instance A, bounded.
    task automatic gap_to_tick_a(output int gap);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (tick_a !== 1'b1 && gap < 64);
    endtask

    // Scoreboard monitor for instance A.
    initial begin
        forever begin
            @(negedge clk);
            if (tick_a === 1'b1) begin
                tick_no++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow tick %0d: led_o=%h mode_o=%0d, expected no tick",
                             tick_no, led_a, mode_oa);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (led_a !== mon_e.led || mode_oa !== mon_e.mode) begin
                        errors++;
                        $display("FAIL sb_tick %0d: led_o=%h mode_o=%0d, expected led_o=%h mode_o=%0d",
                                 tick_no, led_a, mode_oa, mon_e.led, mon_e.mode);
                    end else begin
                        $display("tick %0d: led_o=%h mode_o=%0d ok", tick_no, led_a, mode_oa);
                    end
                end
            end
        end
    end

    // Global guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        int cnt;

        rst_a   = 1'b0;
        en_a    = 1'b1;
        mode_ia = 2'd0;
        rst_b   = 1'b0;
        en_b    = 1'b1;
        mode_ib = 2'd2;

        // ---- Reset state ----
        repeat (2) @(negedge clk);
        check("rst_led_a",  32'(led_a),   32'hF);
        check("rst_tick_a", 32'(tick_a),  32'h0);
        check("rst_mode_a", 32'(mode_oa), 32'h0);
        check("rst_led_b",  32'(led_b),   32'h0);

        // ---- Binary count ----
        for (int i = 0; i < 17; i++) push_exp(bin_exp[i], 2'd0);
        rst_a = 1'b1;
        wait_ticks(1'b0, 1);
        gap_to_tick_a(gap);
        check("tick_period", 32'(gap), 32'd4);
        wait_ticks(1'b0, 15);

        // ---- Gray count, mode_i=1 from reset ----
        rst_a   = 1'b0;
        mode_ia = 2'd1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 11; i++) push_exp(gray_exp[i], gray_mode[i]);
        rst_a = 1'b1;
        wait_ticks(1'b0, 11);

        // ---- Scanner ----
        rst_a   = 1'b0;
        mode_ia = 2'd2;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 12; i++) push_exp(scan_exp[i], scan_mode[i]);
        rst_a = 1'b1;
        wait_ticks(1'b0, 12);

        // ---- Mode change mid-period ----
        for (int i = 0; i < 7; i++) push_exp(chg_exp[i], chg_mode[i]);
        repeat (2) @(negedge clk);
        mode_ia = 2'd0;
        @(negedge clk);
        check("mode_hold_mid_period", 32'(mode_oa), 32'd2);
        wait_ticks(1'b0, 4);
        repeat (2) @(negedge clk);
        mode_ia = 2'd2;
        wait_ticks(1'b0, 3);

        // ---- Enable freeze ----
        @(negedge clk);
        en_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("freeze_led",  32'(led_a),  32'hD);
            check("freeze_tick", 32'(tick_a), 32'h0);
        end
        push_exp(4'hB, 2'd2);
        en_a = 1'b1;
        gap_to_tick_a(gap);
        check("presc_frozen", 32'(gap), 32'd3);

        // ---- Asynchronous reset between edges ----
        @(negedge clk);
        #2;
        rst_a = 1'b0;
        #1;
        check("async_rst_led",  32'(led_a),   32'hF);
        check("async_rst_tick", 32'(tick_a),  32'h0);
        check("async_rst_mode", 32'(mode_oa), 32'h0);
        check("sb_drained",     32'(sb_q.size()), 32'd0);

        // ---- Instance B: single-LED scanner, active high ----
        @(negedge clk);
        rst_b = 1'b1;
        wait_ticks(1'b1, 1);
        check("b_scan_first", 32'(led_b), 32'h0);
        for (int i = 0; i < 4; i++) begin
            wait_ticks(1'b1, 1);
            check("b_scan_lit", 32'(led_b), 32'h1);
        end

        // ---- Instance B: breathing duty per level ----
        @(negedge clk);
        rst_b   = 1'b0;
        mode_ib = 2'd3;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        wait_ticks(1'b1, 1);
        @(negedge clk);
        for (int w = 0; w < 16; w++) begin
            cnt = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (led_b == 1'b1) cnt++;
            end
            check($sformatf("b_duty_w%0d", w), 32'(cnt), 32'(duty_exp[w]));
        end
        check("b_mode", 32'(mode_ob), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
